joybus_frame_receiver: RTL and testbench
========================================

# joybus_frame_receiver

Parametrised N64 joybus receiver: oversamples the raw single-wire controller line, decodes pulse-width bits (short low = 1, long low = 0), and assembles a frame of FRAME_BITS bits terminated by a stop pulse. It is the successor to the fixed 33-bit, externally clocked serial-to-parallel stage. It runs on the system clock, adds framing and timeout checking, and hands a completed word to the button converter with a one-cycle valid strobe.

## Interface
- CLKS_PER_US, default 4: system clock cycles per microsecond of line time.
- FRAME_BITS, default 32: data bits per frame, excluding the stop pulse.
- TIMEOUT_US, default 8: maximum high gap between bits before the frame is abandoned.
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data  input  1  raw joybus line, asynchronous to clock; idle high.
- arm  input  1  single-cycle request to receive one frame.
- frame_out  output  FRAME_BITS  last successfully received frame; first wire bit lands in the MSB.
- frame_valid  output  1  one-cycle pulse when frame_out is updated.
- frame_error  output  1  one-cycle pulse when a frame is abandoned.
- busy  output  1  high in every state except IDLE.

## Operation
- data passes through a 2-flop synchronizer to give `ds`. `dp` is `ds` delayed by one cycle. Fall = dp & ~ds. Rise = ~dp & ds.
- Derived constants:
  - THRESH = 2*CLKS_PER_US
  - LOW_MAX = 4*CLKS_PER_US
  - GAP_MAX = TIMEOUT_US*CLKS_PER_US
- Single counter `cnt`, width $clog2(GAP_MAX+1), saturating. Bit counter `nbits`, width $clog2(FRAME_BITS+1).
- States:
  - IDLE: arm -> WAIT_FIRST, nbits=0. arm is ignored in any other state.
  - WAIT_FIRST: waits with no timeout. Fall -> LOW, cnt=1.
  - LOW: each cycle with ds low, cnt+1.
    - cnt reaching LOW_MAX while still low -> ERR.
    - Rise with nbits<FRAME_BITS: shift in bit = (cnt < THRESH) at the LSB (shift left), nbits+1, -> HIGH, cnt=1.
    - Rise with nbits==FRAME_BITS: this was the stop pulse -> DONE. The stop pulse's bit value is ignored.
  - HIGH: each cycle with ds high, cnt+1.
    - Fall -> LOW, cnt=1.
    - cnt reaching GAP_MAX -> ERR.
  - DONE: copy the shift register to frame_out, frame_valid=1, -> IDLE.
  - ERR: frame_error=1, frame_out unchanged, -> IDLE.
- Boundaries:
  - cnt == THRESH exactly decodes as 0. cnt == THRESH-1 decodes as 1.
  - A fall in the same cycle that cnt hits GAP_MAX: the fall wins, -> LOW.
  - A rise in the same cycle that cnt hits LOW_MAX: the rise wins and the bit decodes as 0.
  - Reset mid-frame: immediate return to IDLE, partial frame discarded.
  - arm coincident with DONE/ERR: ignored, because the state is not IDLE that cycle.

## Timing
- Reset values: frame_out=0, frame_valid=0, frame_error=0, busy=0, state IDLE, synchronizer flops=1.
- Edge detection latency is 3 clocks after a raw data transition (2 synchronizer + 1 edge register).
- frame_valid is asserted in the cycle after the stop pulse's rise is detected. frame_out is stable from that cycle until the next frame_valid.
- frame_valid and frame_error are never asserted together and always last exactly one cycle.
- busy rises the cycle after arm is accepted. It falls in the same cycle the module returns to IDLE, which is the cycle after the frame_valid/frame_error pulse.
- Minimum re-arm spacing: 1 cycle after busy falls.

## Structure
- joybus_pkg holds:
  - the state enum (IDLE, WAIT_FIRST, LOW, HIGH, DONE, ERR)
  - THRESH/LOW_MAX/GAP_MAX as functions of the parameters
  - the default timing constants shared with the future joybus transmitter
- Sub-module joybus_sync_edge: 2-flop synchronizer plus rise/fall detector, reset to high. It is reused by the transmitter's readback path.

## Test plan
(CLKS_PER_US=4, FRAME_BITS=8, TIMEOUT_US=8; bit 1 = low 4 / high 12 cycles, bit 0 = low 12 / high 4, stop = low 8.)
- Reset, arm, send 8'hA5 + stop -> one frame_valid pulse with frame_out=8'hA5, frame_error never high, busy low after the pulse.
- Low widths of 7 and 8 cycles -> decoded as 1 and 0 respectively.
- Send 5 bits, then hold the line high for 40 cycles -> frame_error pulse about 32 cycles after the last rise, frame_out retains its previous value.
- Hold the line low for 20 cycles on bit 3 -> frame_error pulse when cnt reaches 16, then back to IDLE. A new arm plus 8'h3C is received correctly.
- Assert reset mid-frame after 4 bits, release, arm, send 8'hFF -> frame_out=8'hFF with no stale bits.
- Pulse arm during a frame and during the DONE cycle -> no effect. Back-to-back frames 8'h01 then 8'h80 with a re-arm between them -> two valid pulses, correct values.

Source files
------------

// File: rtl/joybus_pkg.sv
// Shared joybus definitions: FSM states, default line timing and the
// derived cycle-count thresholds used by the receiver (and transmitter).
package joybus_pkg;

   localparam int DEF_CLKS_PER_US = 4;
   localparam int DEF_FRAME_BITS  = 32;
   localparam int DEF_TIMEOUT_US  = 8;

   typedef enum logic [2:0] {
      IDLE, WAIT_FIRST, LOW, HIGH, DONE, ERR
   } state_t;

   // Low time below 2 us decodes as a 1, at or above as a 0.
   function automatic int thresh(input int clks_per_us);
      return 2 * clks_per_us;
   endfunction

   // Longest legal low pulse.
   function automatic int low_max(input int clks_per_us);
      return 4 * clks_per_us;
   endfunction

   // Longest legal high gap between bits.
   function automatic int gap_max(input int clks_per_us, input int timeout_us);
      return timeout_us * clks_per_us;
   endfunction

endpackage

// File: rtl/joybus_frame_receiver_if.sv
// Line side and frame side signals of the joybus receiver.
interface joybus_frame_receiver_if
   import joybus_pkg::*;
#(
   parameter int FRAME_BITS = DEF_FRAME_BITS
);
   logic                  data;
   logic                  arm;
   logic [FRAME_BITS-1:0] frame_out;
   logic                  frame_valid;
   logic                  frame_error;
   logic                  busy;

   modport master (output data, arm,
                   input  frame_out, frame_valid, frame_error, busy);
   modport slave  (input  data, arm,
                   output frame_out, frame_valid, frame_error, busy);
endinterface

// File: rtl/joybus_sync_edge.sv
// Two-flop synchronizer for the asynchronous joybus line plus a one-cycle
// delayed copy for rise/fall detection. Resets to the idle-high level so no
// spurious edge is seen coming out of reset.
module joybus_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_data,
   output logic o_rise,
   output logic o_fall
);
   logic r_meta;
   logic r_ds;
   logic r_dp;

   // Synchronize the line and keep the previous synchronized sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_ds   <= 1'b1;
         r_dp   <= 1'b1;
      end else begin
         r_meta <= i_data;
         r_ds   <= r_meta;
         r_dp   <= r_ds;
      end
   end

   assign o_fall = r_dp & ~r_ds;
   assign o_rise = ~r_dp & r_ds;
endmodule

// File: rtl/joybus_frame_receiver.sv
// Joybus frame receiver: measures low-pulse widths to decode bits, collects
// FRAME_BITS of them followed by a stop pulse, and flags malformed frames.
module joybus_frame_receiver
   import joybus_pkg::*;
#(
   parameter int CLKS_PER_US = DEF_CLKS_PER_US,
   parameter int FRAME_BITS  = DEF_FRAME_BITS,
   parameter int TIMEOUT_US  = DEF_TIMEOUT_US
) (
   input  logic              clock,
   input  logic              reset,
   joybus_frame_receiver_if.slave bus
);
   localparam int GAP = gap_max(CLKS_PER_US, TIMEOUT_US);
   localparam int CW  = $clog2(GAP + 1);
   localparam int NW  = $clog2(FRAME_BITS + 1);

   localparam logic [CW-1:0] C_THRESH = CW'(thresh(CLKS_PER_US));
   localparam logic [CW-1:0] C_LOWMAX = CW'(low_max(CLKS_PER_US));
   localparam logic [CW-1:0] C_GAPMAX = CW'(GAP);
   localparam logic [NW-1:0] C_NBITS  = NW'(FRAME_BITS);

   state_t                r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [NW-1:0]         r_nbits, w_nbits_nxt;
   logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
   logic [FRAME_BITS-1:0] r_frame, w_frame_nxt;
   logic                  w_rise, w_fall, w_bit;

   joybus_sync_edge u_sync (
      .clk    (clock),
      .rst    (reset),
      .i_data (bus.data),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // Saturating so an unexpected long level can never wrap to a small width.
   assign w_cnt_inc = (r_cnt == C_GAPMAX) ? r_cnt : r_cnt + 1'b1;
   assign w_bit     = (r_cnt < C_THRESH);

   // State and datapath registers; reset drops any partial frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_nbits <= '0;
         r_shift <= '0;
         r_frame <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_nbits <= w_nbits_nxt;
         r_shift <= w_shift_nxt;
         r_frame <= w_frame_nxt;
      end
   end

   // Next-state decode. Edges take priority over the width limits so a
   // transition landing on the limit cycle is still accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_nbits_nxt = r_nbits;
      w_shift_nxt = r_shift;
      w_frame_nxt = r_frame;
      unique case (r_state)
         IDLE: begin
            if (bus.arm) begin
               w_state_nxt = WAIT_FIRST;
               w_nbits_nxt = '0;
            end
         end
         WAIT_FIRST: begin
            if (w_fall) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = CW'(1);
            end
         end
         LOW: begin
            if (w_rise) begin
               if (r_nbits < C_NBITS) begin
                  w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_bit};
                  w_nbits_nxt = r_nbits + 1'b1;
                  w_state_nxt = HIGH;
                  w_cnt_nxt   = CW'(1);
               end else begin
                  // Stop pulse: publish so frame_out is valid alongside the strobe.
                  w_frame_nxt = r_shift;
                  w_state_nxt = DONE;
               end
            end else if (r_cnt >= C_LOWMAX) begin
               w_state_nxt = ERR;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         HIGH: begin
            if (w_fall) begin
               w_state_nxt = LOW;
               w_cnt_nxt   = CW'(1);
            end else if (r_cnt >= C_GAPMAX) begin
               w_state_nxt = ERR;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         DONE:    w_state_nxt = IDLE;
         ERR:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.frame_out   = r_frame;
   assign bus.frame_valid = (r_state == DONE);
   assign bus.frame_error = (r_state == ERR);
   assign bus.busy        = (r_state != IDLE);
endmodule

// File: tb/tb_joybus_frame_receiver.sv
// Directed bench for the joybus receiver: a table of whole frames with
// optional width overrides on the first bit, plus hand sequences for
// timeouts, over-long lows and reset mid-frame.
module tb_joybus_frame_receiver;
   import joybus_pkg::*;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   v_cnt  = 0;
   int   e_cnt  = 0;
   int   both   = 0;
   int   exp_v  = 0;
   int   exp_e  = 0;

   joybus_frame_receiver_if #(.FRAME_BITS(8)) bus ();

   joybus_frame_receiver #(.CLKS_PER_US(4), .FRAME_BITS(8), .TIMEOUT_US(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse bookkeeping, sampled away from the active edge.
   always @(negedge clock) begin
      if (bus.frame_valid) v_cnt++;
      if (bus.frame_error) e_cnt++;
      if (bus.frame_valid && bus.frame_error) both++;
   end

   typedef struct {
      logic [7:0] tx;
      int         ov_low;
      int         ov_high;
      bit         arm_mid;
      bit         arm_done;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_arm();
      @(negedge clock);
      bus.arm = 1'b1;
      @(negedge clock);
      bus.arm = 1'b0;
   endtask

   // Called at a negedge; low and high widths are in clock cycles.
   task automatic send_bit(input int low, input int high, input bit arm_pulse);
      bus.data = 1'b0;
      repeat (low) @(negedge clock);
      bus.data = 1'b1;
      if (arm_pulse) begin
         bus.arm = 1'b1;
         @(negedge clock);
         bus.arm = 1'b0;
         repeat (high - 1) @(negedge clock);
      end else begin
         repeat (high) @(negedge clock);
      end
   endtask

   task automatic send_frame(input vec_t v, input string tag);
      int  lo, hi;
      bit  got;
      do_arm();
      chk({tag, " busy_after_arm"}, 32'(bus.busy), 32'd1);
      repeat (4) @(negedge clock);
      for (int i = 7; i >= 0; i--) begin
         lo = v.tx[i] ? 4 : 12;
         hi = v.tx[i] ? 12 : 4;
         if (i == 7 && v.ov_low  != 0) lo = v.ov_low;
         if (i == 7 && v.ov_high != 0) hi = v.ov_high;
         send_bit(lo, hi, v.arm_mid && i == 3);
      end
      bus.data = 1'b0;
      repeat (8) @(negedge clock);
      bus.data = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clock);
         if (bus.frame_valid) got = 1'b1;
      end
      if (!got) begin
         chk({tag, " valid_timeout"}, 32'd0, 32'd1);
      end else begin
         exp_v++;
         chk({tag, " frame_out"}, 32'(bus.frame_out), 32'(v.exp));
         if (v.arm_done) bus.arm = 1'b1;
         @(negedge clock);
         bus.arm = 1'b0;
         chk({tag, " valid_one_cycle"}, 32'(bus.frame_valid), 32'd0);
         chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
         if (v.arm_done) begin
            repeat (3) @(negedge clock);
            chk({tag, " arm_in_done_ignored"}, 32'(bus.busy), 32'd0);
         end
      end
      #1;
      chk({tag, " err_count"}, 32'(e_cnt), 32'(exp_e));
   endtask

   initial begin
      int k_err;
      vec_t v;

      vecs[0] = '{8'hA5,  0,  0, 1'b0, 1'b0, 8'hA5};
      vecs[1] = '{8'h00,  7,  0, 1'b0, 1'b0, 8'h80};  // 7-cycle low -> 1
      vecs[2] = '{8'hFF,  8,  0, 1'b0, 1'b0, 8'h7F};  // 8-cycle low -> 0
      vecs[3] = '{8'hFF, 16,  0, 1'b0, 1'b0, 8'h7F};  // rise on LOW_MAX wins
      vecs[4] = '{8'hA5,  0, 32, 1'b0, 1'b0, 8'hA5};  // fall on GAP_MAX wins
      vecs[5] = '{8'h01,  0,  0, 1'b1, 1'b0, 8'h01};  // arm mid-frame
      vecs[6] = '{8'h80,  0,  0, 1'b0, 1'b1, 8'h80};  // arm in DONE cycle

      reset = 1'b1;
      bus.data = 1'b1;
      bus.arm  = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset frame_out",   32'(bus.frame_out),   32'd0);
      chk("reset frame_valid", 32'(bus.frame_valid), 32'd0);
      chk("reset frame_error", 32'(bus.frame_error), 32'd0);
      chk("reset busy",        32'(bus.busy),        32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      for (int i = 0; i < 7; i++) send_frame(vecs[i], $sformatf("vec%0d", i));

      // Gap timeout after the fifth bit.
      do_arm();
      repeat (4) @(negedge clock);
      send_bit(4, 12, 1'b0);
      send_bit(12, 4, 1'b0);
      send_bit(4, 12, 1'b0);
      send_bit(4, 12, 1'b0);
      bus.data = 1'b0;
      repeat (4) @(negedge clock);
      bus.data = 1'b1;
      k_err = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (bus.frame_error && k_err < 0) k_err = k;
      end
      exp_e++;
      chk("timeout latency", 32'(k_err), 32'd35);
      chk("timeout frame_out kept", 32'(bus.frame_out), 32'h80);
      chk("timeout busy", 32'(bus.busy), 32'd0);
      #1;
      chk("timeout err_count", 32'(e_cnt), 32'(exp_e));

      // Low held too long on bit 3.
      do_arm();
      repeat (4) @(negedge clock);
      send_bit(12, 4, 1'b0);
      send_bit(12, 4, 1'b0);
      send_bit(4, 12, 1'b0);
      bus.data = 1'b0;
      k_err = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (bus.frame_error && k_err < 0) k_err = k;
      end
      bus.data = 1'b1;
      repeat (6) @(negedge clock);
      exp_e++;
      chk("lowhold latency", 32'(k_err), 32'd19);
      chk("lowhold busy", 32'(bus.busy), 32'd0);
      v = '{8'h3C, 0, 0, 1'b0, 1'b0, 8'h3C};
      send_frame(v, "after_lowhold");

      // Reset after four bits; partial frame must vanish.
      do_arm();
      repeat (4) @(negedge clock);
      for (int i = 0; i < 4; i++) send_bit(12, 4, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      chk("midreset busy", 32'(bus.busy), 32'd0);
      chk("midreset frame_out", 32'(bus.frame_out), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      v = '{8'hFF, 0, 0, 1'b0, 1'b0, 8'hFF};
      send_frame(v, "after_reset");

      repeat (4) @(negedge clock);
      #1;
      chk("total valid pulses", 32'(v_cnt), 32'(exp_v));
      chk("total error pulses", 32'(e_cnt), 32'd2);
      chk("valid_and_error together", 32'(both), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute backstop so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
